// File: rtl/stream_loopback_pu_controller.sv
// Loopback PU controller: stream read -> optional lane-wise add/max with buffer word -> FIFO -> stream write.
// Optional feature macro: LOOPBACK_SAT_EN (signed saturating add in mode 1; default wraps).
`default_nettype none

module stream_loopback_pu_controller #(
    parameter int AXI_DATA_W  = 64,
    parameter int ELEM_W      = 16,
    parameter int FIFO_ADDR_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode_in,
    output logic [1:0]              mode,
    input  logic                    stream_read_ready,
    output logic                    stream_read_req,
    input  logic [AXI_DATA_W-1:0]   stream_read_data,
    input  logic                    buffer_read_ready,
    output logic                    buffer_read_req,
    input  logic [AXI_DATA_W-1:0]   buffer_read_data,
    input  logic                    stream_write_ready,
    output logic                    stream_write_req,
    output logic [AXI_DATA_W-1:0]   stream_write_data,
    output logic [FIFO_ADDR_W:0]    fifo_count,
    output logic                    busy
);

    localparam int LANES = AXI_DATA_W / ELEM_W;
    localparam int DEPTH = 1 << FIFO_ADDR_W;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic                   inflight_q;
    logic [FIFO_ADDR_W-1:0] wr_ptr_q;
    logic [FIFO_ADDR_W-1:0] rd_ptr_q;
    logic [FIFO_ADDR_W:0]   count_q;
    logic [FIFO_ADDR_W:0]   count_d;
    logic [AXI_DATA_W-1:0]  mem_q [DEPTH];

    logic                   paired;
    logic                   can_issue;
    logic                   push;
    logic                   pop;
    logic [FIFO_ADDR_W+1:0] occupancy;
    logic [AXI_DATA_W-1:0]  push_data;

    // Credit: an in-flight word already owns a FIFO slot.
    assign occupancy = {1'b0, count_q} + {{(FIFO_ADDR_W+1){1'b0}}, inflight_q};
    assign paired    = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign can_issue = !reset && (state_q == ST_RUN) && (mode_in == mode_q)
                       && (occupancy < (FIFO_ADDR_W+2)'(DEPTH));

    assign stream_read_req = can_issue && (paired ? (stream_read_ready && buffer_read_ready)
                                                  : stream_read_ready);
    assign buffer_read_req = can_issue && (paired ? (stream_read_ready && buffer_read_ready)
                                                  : buffer_read_ready);

    assign push              = inflight_q;
    assign pop               = stream_write_req;
    assign stream_write_req  = (count_q != '0) && stream_write_ready;
    assign stream_write_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fifo_count        = count_q;
    assign busy              = (count_q != '0) || inflight_q;
    assign mode              = mode_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ELEM_W-1:0] a;
        logic [ELEM_W-1:0] b;
        logic [ELEM_W-1:0] sum;
        logic [ELEM_W-1:0] mx;

        assign a = stream_read_data[l*ELEM_W +: ELEM_W];
        assign b = buffer_read_data[l*ELEM_W +: ELEM_W];
`ifdef LOOPBACK_SAT_EN
        logic [ELEM_W:0] wide;
        assign wide = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
        assign sum  = (wide[ELEM_W] == wide[ELEM_W-1]) ? wide[ELEM_W-1:0]
                    : (wide[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                    : {1'b0, {(ELEM_W-1){1'b1}}});
`else
        assign sum = a + b;
`endif
        assign mx = ($signed(a) > $signed(b)) ? a : b;
        assign push_data[l*ELEM_W +: ELEM_W] = (mode_q == 2'd1) ? sum
                                             : (mode_q == 2'd2) ? mx : a;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            mode_q     <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= stream_read_req;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Mode only switches once nothing is queued or in flight.
            case (state_q)
                ST_RUN: begin
                    if (mode_in != mode_q) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        mode_q  <= mode_in;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_loopback_pu_controller.sv
// Directed self-checking bench for stream_loopback_pu_controller (default parameters).
`default_nettype none

module tb_stream_loopback_pu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode_in = 2'd0;
    logic [1:0]  mode;
    logic        stream_read_ready = 1'b0;
    logic        stream_read_req;
    logic [63:0] stream_read_data = 64'd0;
    logic        buffer_read_ready = 1'b0;
    logic        buffer_read_req;
    logic [63:0] buffer_read_data = 64'd0;
    logic        stream_write_ready = 1'b0;
    logic        stream_write_req;
    logic [63:0] stream_write_data;
    logic [2:0]  fifo_count;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;

    logic [63:0] s_cnt = 64'd0;
    logic        s_fixed = 1'b0;
    logic [63:0] s_fix = 64'd0;
    logic [63:0] b_fix = 64'd0;
    logic [63:0] base;

    stream_loopback_pu_controller #(
        .AXI_DATA_W (64),
        .ELEM_W     (16),
        .FIFO_ADDR_W(2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mode_in           (mode_in),
        .mode              (mode),
        .stream_read_ready (stream_read_ready),
        .stream_read_req   (stream_read_req),
        .stream_read_data  (stream_read_data),
        .buffer_read_ready (buffer_read_ready),
        .buffer_read_req   (buffer_read_req),
        .buffer_read_data  (buffer_read_data),
        .stream_write_ready(stream_write_ready),
        .stream_write_req  (stream_write_req),
        .stream_write_data (stream_write_data),
        .fifo_count        (fifo_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Read-port responders: data appears the cycle after an accepted request.
    always @(posedge clk) begin
        if (stream_read_req) begin
            s_cnt            <= s_cnt + 64'd1;
            stream_read_data <= s_fixed ? s_fix : (s_cnt + 64'd1);
        end
        if (buffer_read_req) begin
            buffer_read_data <= b_fix;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stream_read_ready  = 1'b0;
        buffer_read_ready  = 1'b0;
        stream_write_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mode_in = 2'd0;
        reset   = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        idle_inputs();
        mode_in = m;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (mode === m) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL set_mode: mode=%0d required %0d within 20 cycles", mode, m);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks += 6;
        if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL rst_sreq: got %b want 0", stream_read_req); end
        if (buffer_read_req !== 1'b0) begin n_fail++; $display("FAIL rst_breq: got %b want 0", buffer_read_req); end
        if (stream_write_req !== 1'b0) begin n_fail++; $display("FAIL rst_wreq: got %b want 0", stream_write_req); end
        if (stream_write_data !== 64'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", stream_write_data); end
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_count_busy: got %0d/%b want 0/0", fifo_count, busy); end
        if (mode !== 2'd0) begin n_fail++; $display("FAIL rst_mode: got %0d want 0", mode); end
    endtask

    task automatic test_pass_stream();
        do_reset();
        s_fixed = 1'b0;
        base    = s_cnt;
        for (int k = 0; k < 10; k++) begin
            stream_read_ready  = 1'b1;
            buffer_read_ready  = (k != 5);
            stream_write_ready = 1'b1;
            #1;
            n_checks += 3;
            if (stream_read_req !== 1'b1) begin n_fail++; $display("FAIL pass_sreq[%0d]: got %b want 1", k, stream_read_req); end
            if (buffer_read_req !== (k != 5)) begin n_fail++; $display("FAIL pass_breq[%0d]: got %b want %b", k, buffer_read_req, (k != 5)); end
            if (stream_write_req !== (k >= 2)) begin n_fail++; $display("FAIL pass_wreq[%0d]: got %b want %b", k, stream_write_req, (k >= 2)); end
            if (k >= 2) begin
                n_checks++;
                if (stream_write_data !== base + 64'(k - 1)) begin
                    n_fail++;
                    $display("FAIL pass_wdata[%0d]: got %h want %h", k, stream_write_data, base + 64'(k - 1));
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        s_fixed = 1'b0;
        base    = s_cnt;
        for (int k = 0; k < 10; k++) begin
            stream_read_ready  = 1'b1;
            buffer_read_ready  = 1'b1;
            stream_write_ready = 1'b0;
            #1;
            n_checks++;
            if (stream_read_req !== (k < 4)) begin n_fail++; $display("FAIL bp_sreq[%0d]: got %b want %b", k, stream_read_req, (k < 4)); end
            if (k == 9) begin
                n_checks += 2;
                if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", fifo_count); end
                if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b want 1", busy); end
            end
            cyc();
        end
        for (int k = 10; k < 14; k++) begin
            stream_write_ready = 1'b1;
            #1;
            n_checks += 2;
            if (stream_write_req !== 1'b1) begin n_fail++; $display("FAIL bp_wreq[%0d]: got %b want 1", k, stream_write_req); end
            if (stream_write_data !== base + 64'(k - 9)) begin
                n_fail++;
                $display("FAIL bp_wdata[%0d]: got %h want %h", k, stream_write_data, base + 64'(k - 9));
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic check_combine(input logic [1:0] m, input logic [63:0] sv,
                                 input logic [63:0] bv, input logic [63:0] exp);
        do_reset();
        set_mode(m);
        s_fixed = 1'b1;
        s_fix   = sv;
        b_fix   = bv;
        stream_write_ready = 1'b1;
        stream_read_ready  = 1'b1;
        buffer_read_ready  = 1'b0;
        #1;
        n_checks += 2;
        if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL m%0d_unpaired_sreq: got %b want 0", m, stream_read_req); end
        if (buffer_read_req !== 1'b0) begin n_fail++; $display("FAIL m%0d_unpaired_breq: got %b want 0", m, buffer_read_req); end
        cyc();
        buffer_read_ready = 1'b1;
        #1;
        n_checks++;
        if (stream_read_req !== 1'b1 || buffer_read_req !== 1'b1) begin
            n_fail++;
            $display("FAIL m%0d_paired_req: got %b%b want 11", m, stream_read_req, buffer_read_req);
        end
        cyc();
        stream_read_ready = 1'b0;
        buffer_read_ready = 1'b0;
        #1;
        n_checks++;
        if (stream_write_req !== 1'b0) begin n_fail++; $display("FAIL m%0d_early_wreq: got %b want 0", m, stream_write_req); end
        cyc();
        #1;
        n_checks += 2;
        if (stream_write_req !== 1'b1) begin n_fail++; $display("FAIL m%0d_wreq: got %b want 1", m, stream_write_req); end
        if (stream_write_data !== exp) begin n_fail++; $display("FAIL m%0d_result: got %h want %h", m, stream_write_data, exp); end
        cyc();
        s_fixed = 1'b0;
        idle_inputs();
    endtask

    task automatic test_add();
`ifdef LOOPBACK_SAT_EN
        check_combine(2'd1, 64'h8000_1234_0003_7FFF, 64'h8000_1111_FFFF_0001, 64'h8000_2345_0002_7FFF);
`else
        check_combine(2'd1, 64'h8000_1234_0003_7FFF, 64'h8000_1111_FFFF_0001, 64'h0000_2345_0002_8000);
`endif
    endtask

    task automatic test_max();
        check_combine(2'd2, 64'h8000_7FFF_0005_FFFE, 64'h7FFF_8000_FFFB_0001, 64'h7FFF_7FFF_0005_0001);
    endtask

    task automatic test_mode_drain();
        do_reset();
        s_fixed = 1'b0;
        base    = s_cnt;
        for (int k = 0; k < 3; k++) begin
            stream_read_ready = 1'b1;
            buffer_read_ready = 1'b1;
            cyc();
        end
        idle_inputs();
        cyc();
        #1;
        n_checks++;
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL drain_fill: got %0d want 3", fifo_count); end
        mode_in = 2'd1;
        cyc();
        stream_read_ready = 1'b1;
        buffer_read_ready = 1'b1;
        #1;
        n_checks += 2;
        if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL drain_sreq: got %b want 0", stream_read_req); end
        if (mode !== 2'd0) begin n_fail++; $display("FAIL drain_mode_hold: got %0d want 0", mode); end
        cyc();
        for (int k = 6; k < 9; k++) begin
            stream_write_ready = 1'b1;
            #1;
            n_checks += 2;
            if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL drain_sreq[%0d]: got %b want 0", k, stream_read_req); end
            if (stream_write_req !== 1'b1 || stream_write_data !== base + 64'(k - 5)) begin
                n_fail++;
                $display("FAIL drain_wdata[%0d]: got %b/%h want 1/%h", k, stream_write_req, stream_write_data, base + 64'(k - 5));
            end
            cyc();
        end
        #1;
        n_checks += 2;
        if (busy !== 1'b0 || mode !== 2'd0) begin n_fail++; $display("FAIL drain_idle: got busy=%b mode=%0d want 0/0", busy, mode); end
        if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL drain_idle_sreq: got %b want 0", stream_read_req); end
        cyc();
        #1;
        n_checks += 2;
        if (mode !== 2'd1) begin n_fail++; $display("FAIL drain_newmode: got %0d want 1", mode); end
        if (stream_read_req !== 1'b1 || buffer_read_req !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_first_paired: got %b%b want 11", stream_read_req, buffer_read_req);
        end
        cyc();
        idle_inputs();
        mode_in = 2'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_fixed = 1'b0;
        base    = s_cnt;
        for (int k = 0; k < 4; k++) begin
            stream_read_ready = 1'b1;
            buffer_read_ready = 1'b1;
            cyc();
        end
        #1;
        n_checks += 2;
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL rmid_count: got %0d want 3", fifo_count); end
        if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL rmid_credit: got %b want 0", stream_read_req); end
        reset = 1'b1;
        stream_write_ready = 1'b1;
        #1;
        n_checks += 4;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got %0d/%b want 0/0", fifo_count, busy); end
        if (stream_write_req !== 1'b0) begin n_fail++; $display("FAIL rmid_wreq: got %b want 0", stream_write_req); end
        if (stream_write_data !== 64'd0) begin n_fail++; $display("FAIL rmid_wdata: got %h want 0", stream_write_data); end
        if (stream_read_req !== 1'b0) begin n_fail++; $display("FAIL rmid_sreq: got %b want 0", stream_read_req); end
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        n_checks++;
        if (stream_read_req !== 1'b1) begin n_fail++; $display("FAIL rmid_restart: got %b want 1", stream_read_req); end
        cyc();
        stream_read_ready = 1'b0;
        #1;
        n_checks++;
        if (stream_write_req !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got %b want 0", stream_write_req); end
        cyc();
        #1;
        n_checks++;
        if (stream_write_req !== 1'b1 || stream_write_data !== base + 64'd5) begin
            n_fail++;
            $display("FAIL rmid_newword: got %b/%h want 1/%h", stream_write_req, stream_write_data, base + 64'd5);
        end
        cyc();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pass_stream();
        test_backpressure();
        test_add();
        test_max();
        test_mode_drain();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
